// File: rtl/rv_banked_ram.sv
// rv_banked_ram
//
// Banked on-chip RAM slave for the picorv32 native memory bus. The address
// window [BASE_ADDR, BASE_ADDR + NUM_BANKS * 2^(BANK_AW+2)) is split into
// NUM_BANKS power-of-two banks of byte-writable synchronous RAM. Each accepted
// request produces exactly one single-cycle mem_ready pulse after READ_LATENCY
// cycles. The lowest ROM_BANKS banks reject writes and raise a sticky err.
//
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   mem_valid  in   bus request
//   mem_addr   in   byte address, [1:0] ignored
//   mem_wdata  in   write data
//   mem_wstrb  in   byte enables, 0 = read
//   mem_ready  out  one-cycle completion pulse
//   mem_rdata  out  read data, zero unless mem_ready
//   hit        out  combinational: mem_valid and address inside the window
//   busy       out  controller not idle
//   err        out  sticky: a write targeted a ROM bank
//   err_clr    in   synchronous clear of err (a same-cycle set wins)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a hit; the accept edge commits the write and reads RAM
// WAIT  | second latency cycle, RAM output copied into the pipeline register
// RESP  | mem_ready high for this single cycle, then back to IDLE

module rv_banked_ram #(
    parameter int          NUM_BANKS    = 8,
    parameter int          BANK_AW      = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1,
    parameter int          ROM_BANKS    = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        hit,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    localparam int BANK_W  = $clog2(NUM_BANKS);
    // A one-bank build still needs a 1-bit index register; it is always 0.
    localparam int BANK_IW = (BANK_W == 0) ? 1 : BANK_W;
    localparam int WIN_AW  = BANK_AW + 2 + BANK_W;
    localparam int DEPTH   = 1 << BANK_AW;

    function automatic logic [NUM_BANKS-1:0] rom_mask_f();
        logic [NUM_BANKS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (i < ROM_BANKS) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NUM_BANKS-1:0] ROM_MASK = rom_mask_f();

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]        off;
    logic [BANK_IW-1:0] bank_idx;
    logic [BANK_AW-1:0] word_idx;
    logic               accept;
    logic               rom_sel;
    logic               err_set;
    logic [BANK_IW-1:0] bank_q;
    logic [31:0]        bank_rd [NUM_BANKS];
    logic [31:0]        rd_mux;
    logic [31:0]        rdata_pipe;

    // Window is aligned to its own size, so membership is an upper-bit match.
    assign hit      = mem_valid && ((mem_addr >> WIN_AW) == (BASE_ADDR >> WIN_AW));
    assign off      = mem_addr - BASE_ADDR;
    assign bank_idx = BANK_IW'(off >> (BANK_AW + 2));
    assign word_idx = BANK_AW'(off >> 2);

    assign accept  = (state_q == IDLE) && hit;
    assign rom_sel = ROM_MASK[bank_idx];
    assign err_set = accept && (mem_wstrb != 4'h0) && rom_sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (READ_LATENCY == 2) ? WAIT : RESP;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     bank_q <= '0;
        else if (accept) bank_q <= bank_idx;
    end

    // Each bank reads and writes only on the accept edge, so a request held
    // high through WAIT/RESP can never write twice. Non-blocking update gives
    // read-first data on a write.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [31:0] ram [DEPTH];
        logic [31:0] dout;
        logic        sel;

        assign sel = accept && (bank_idx == BANK_IW'(b));

        always_ff @(posedge clk) begin
            if (sel) begin
                dout <= ram[word_idx];
                if (!ROM_MASK[b]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mem_wstrb[i]) ram[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                    end
                end
            end
        end

        assign bank_rd[b] = dout;
    end

    assign rd_mux = bank_rd[bank_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               rdata_pipe <= '0;
        else if (state_q == WAIT)  rdata_pipe <= rd_mux;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      err <= 1'b0;
        else if (err_set) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

    assign mem_ready = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign mem_rdata = mem_ready ? ((READ_LATENCY == 2) ? rdata_pipe : rd_mux) : 32'h0;

endmodule
